// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head word is visible combinationally while not empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: drives the PC register, issues in-order imem reads, buffers words for decode
// and discards responses made stale by a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] remaining;
  logic [CW-1:0] a_count;
  logic [CW-1:0] q_count;
  logic [CW:0]   in_flight;
  logic [31:0]   a_head;
  logic          a_full, a_empty, q_full, q_empty;
  fetch_entry_t  q_in, q_head;
  logic          accept, rsp_take, rsp_keep, dec_fire;

  // Credit covers both in-flight reads and buffered words, so the queue can never overflow.
  assign in_flight      = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req_valid = !reset && (state == RUN) && !redirect_valid &&
                          (in_flight < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid & imem_req_ready;

  assign pc_en   = redirect_valid | accept;
  assign pc_next = redirect_valid ? {redirect_target[31:2], 2'b00} : pc + 32'd4;

  assign rsp_take  = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep  = rsp_take && (state == RUN) && !redirect_valid;
  assign remaining = outstanding - CW'(rsp_take);

  assign q_in      = '{pc: a_head, instr: imem_rsp_data};
  assign dec_valid = !q_empty;
  assign dec_fire  = dec_valid & dec_ready;
  assign dec_instr = q_empty ? 32'd0 : q_head.instr;
  assign dec_pc    = q_empty ? 32'd0 : q_head.pc;

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (pc),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .head      (a_head),
    .count     (a_count),
    .full      (a_full),
    .empty     (a_empty)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (q_in),
    .pop       (dec_fire),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp_take);
      if (redirect_valid) begin
        drop_cnt <= remaining;
        state    <= (remaining == '0) ? RUN : FLUSH;
      end else if ((state == FLUSH) && rsp_take) begin
        drop_cnt <= drop_cnt - CW'(1);
        if (drop_cnt == CW'(1)) state <= RUN;
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> (outstanding != '0));

  logic unused_ok;
  assign unused_ok = ^{redirect_target[1:0], a_count, a_full, a_empty, q_full, RESET_PC};

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order memory model, PC register model and decode-stream checker.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_next         (pc_next),
    .pc_en           (pc_en),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc)
  );

  always #5 clk = ~clk;

  // Program counter register sitting outside the fetch unit.
  always @(posedge clk or posedge reset) begin
    if (reset)      pc <= RESET_PC;
    else if (pc_en) pc <= pc_next;
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Instruction memory: in-order responses after a per-request latency.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  int cyc = 0, last_due = 0, acc_total = 0, lat = 1, m_lat = 0, m_due = 0;
  bit lat_rand = 1'b0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      mem_q.delete();
      last_due = 0;
    end else if (imem_req_valid && imem_req_ready) begin
      m_lat = lat_rand ? int'($urandom_range(1, 4)) : lat;
      m_due = cyc + m_lat;
      if (m_due <= last_due) m_due = last_due + 1;
      last_due = m_due;
      mem_q.push_back('{addr: imem_req_addr, due: m_due});
      acc_total++;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
    end
  end

  // Expected decode stream: sequential words from the latest reset/redirect target.
  fetch_entry_t exp_q[$];
  fetch_entry_t exp_e;
  logic [31:0]  exp_next = RESET_PC;
  int           deliv_total = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_q.delete();
      exp_next = RESET_PC;
    end else begin
      while (exp_q.size() < 4) begin
        exp_q.push_back('{pc: exp_next, instr: word_at(exp_next)});
        exp_next += 32'd4;
      end
      if (dec_valid && dec_ready) begin
        exp_e = exp_q.pop_front();
        check("dec_pc", dec_pc, exp_e.pc);
        check("dec_instr", dec_instr, exp_e.instr);
        deliv_total++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_next = {redirect_target[31:2], 2'b00};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dec(input logic [31:0] exp, input string name);
    int n = 0;
    @(negedge clk);
    while (!dec_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 32'(dec_valid), 32'd1);
    check(name, dec_pc, exp);
  endtask

  initial begin
    logic [31:0] held;
    int d0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    check("rst_dec_instr", dec_instr, 32'd0);

    // Boot fetch with single-cycle memory.
    tick();
    imem_req_ready = 1'b1; dec_ready = 1'b1; lat = 1; reset = 1'b0;
    @(negedge clk);
    check("t1_req_valid", 32'(imem_req_valid), 32'd1);
    check("t1_req_addr", imem_req_addr, 32'h0040_0000);
    check("t1_pc_next", pc_next, 32'h0040_0004);
    check("t1_pc_en", 32'(pc_en), 32'd1);
    wait_dec(32'h0040_0000, "t1_dec0");
    @(negedge clk);
    check("t1_dec1", dec_pc, 32'h0040_0004);
    @(negedge clk);
    check("t1_dec2", dec_pc, 32'h0040_0008);

    // Decode stalls: buffering stops at DEPTH words.
    tick();
    dec_ready = 1'b0;
    repeat (12) @(negedge clk);
    check("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_held", 32'(acc_total - deliv_total), 32'd4);
    d0 = deliv_total;
    tick();
    dec_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_drained", 32'(deliv_total - d0 >= 4), 32'd1);

    // Memory back-pressure holds the request.
    tick();
    imem_req_ready = 1'b0;
    @(negedge clk);
    held = pc;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("t3_pc_en", 32'(pc_en), 32'd0);
      check("t3_req_valid", 32'(imem_req_valid), 32'd1);
      check("t3_addr", imem_req_addr, held);
      check("t3_pc", pc, held);
    end

    // Redirect with two reads outstanding on a 3-cycle memory.
    lat = 3;
    repeat (6) @(negedge clk);
    tick(); imem_req_ready = 1'b1;
    tick();
    tick(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0100;
    @(negedge clk);
    check("t4_pc_en", 32'(pc_en), 32'd1);
    check("t4_pc_next", pc_next, 32'h0040_0100);
    check("t4_outstanding", 32'(dut.outstanding), 32'd2);
    tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    check("t4_flush", 32'(dut.state), 32'(FLUSH));
    check("t4_no_issue", 32'(imem_req_valid), 32'd0);
    wait_dec(32'h0040_0100, "t4_dec");
    check("t4_run", 32'(dut.state), 32'(RUN));

    // Unaligned redirect coinciding with a response.
    tick(); imem_req_ready = 1'b0; lat = 2;
    repeat (8) @(negedge clk);
    tick(); imem_req_ready = 1'b1;
    tick(); imem_req_ready = 1'b0;
    tick(); redirect_valid = 1'b1; redirect_target = 32'h0040_0103;
    @(negedge clk);
    check("t5_pc_next", pc_next, 32'h0040_0100);
    check("t5_pc_en", 32'(pc_en), 32'd1);
    tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    check("t5_state", 32'(dut.state), 32'(RUN));
    wait_dec(32'h0040_0100, "t5_dec");

    // Reset while flushing.
    tick(); imem_req_ready = 1'b0; lat = 3;
    repeat (8) @(negedge clk);
    tick(); imem_req_ready = 1'b1;
    tick();
    tick(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0200;
    tick(); redirect_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("t6_dec_valid", 32'(dec_valid), 32'd0);
    check("t6_outstanding", 32'(dut.outstanding), 32'd0);
    check("t6_drop_cnt", 32'(dut.drop_cnt), 32'd0);
    check("t6_req_valid", 32'(imem_req_valid), 32'd0);
    tick(); reset = 1'b0; imem_req_ready = 1'b1;
    @(negedge clk);
    check("t6_req_valid_after", 32'(imem_req_valid), 32'd1);
    check("t6_req_addr", imem_req_addr, 32'h0040_0000);

    // Random traffic: ready jitter, variable latency, sporadic redirects.
    lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      dec_ready      = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 3) begin
        redirect_valid  = 1'b1;
        redirect_target = {20'h00400, 12'($urandom)};
      end else begin
        redirect_valid = 1'b0;
      end
    end
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1; lat_rand = 1'b0;
    repeat (5) @(negedge clk);
    d0 = deliv_total;
    repeat (30) @(negedge clk);
    check("progress", 32'(deliv_total - d0 >= 20), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
